// File: rtl/snake_scan_ctrl_if.sv
// snake_scan_ctrl_if: control, status and window-coordinate bundle between the layer controller and snake_scan_ctrl
interface snake_scan_ctrl_if #(parameter int DIM_W = 9);
  logic             start;
  logic [DIM_W-1:0] row;
  logic [DIM_W-1:0] col;
  logic             busy;
  logic             done;
  logic             cfg_err;
  logic             stack_en;
  logic             shift_dir;
  logic             turn;
  logic             win_valid;
  logic [DIM_W-1:0] win_row;
  logic [DIM_W-1:0] win_col;
  logic [19:0]      cycle_cnt;
  modport master (
    output start, row, col,
    input  busy, done, cfg_err, stack_en, shift_dir, turn, win_valid, win_row, win_col, cycle_cnt
  );
  modport slave (
    input  start, row, col,
    output busy, done, cfg_err, stack_en, shift_dir, turn, win_valid, win_row, win_col, cycle_cnt
  );
endinterface

// File: rtl/snake_scan_ctrl.sv
// snake_scan_ctrl: serpentine KxK window scan sequencer for one layer pass.
// Optional busy-cycle counter built only when SNAKE_CTRL_STATS_EN is defined.
module snake_scan_ctrl #(
  parameter int DIM_W = 9,
  parameter int K     = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  snake_scan_ctrl_if.slave    bus
);
  typedef enum logic [2:0] {IDLE, SETUP, RUN, TURN, DONE} state_t;
  localparam logic [DIM_W-1:0] KW  = DIM_W'(K);
  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);
  state_t           state_q, state_d;
  logic [DIM_W-1:0] lim_r_q, lim_r_d, lim_c_q, lim_c_d;
  logic [DIM_W-1:0] wr_q, wr_d, wc_q, wc_d;
  logic             dir_q, dir_d, err_q, err_d, row_end;
  always_comb begin
    state_d = state_q;
    lim_r_d = lim_r_q;
    lim_c_d = lim_c_q;
    wr_d    = wr_q;
    wc_d    = wc_q;
    dir_d   = dir_q;
    err_d   = 1'b0;
    row_end = dir_q ? (wc_q == '0) : (wc_q == lim_c_q);
    case (state_q)
      IDLE: if (bus.start) begin
        if (bus.row < KW || bus.col < KW) begin
          err_d = 1'b1;
        end else begin
          state_d = SETUP;
          lim_r_d = bus.row - KW;
          lim_c_d = bus.col - KW;
          wr_d    = '0;
          wc_d    = '0;
          dir_d   = 1'b0;
        end
      end
      SETUP: state_d = RUN;
      RUN: if (row_end) state_d = (wr_q < lim_r_q) ? TURN : DONE;
        else wc_d = dir_q ? wc_q - ONE : wc_q + ONE;
      // the column is not stepped here, so the new row starts on the end column
      TURN: begin
        state_d = RUN;
        wr_d    = wr_q + ONE;
        dir_d   = ~dir_q;
      end
      DONE: begin
        state_d = IDLE;
        wr_d    = '0;
        wc_d    = '0;
        dir_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lim_r_q <= '0;
      lim_c_q <= '0;
      wr_q    <= '0;
      wc_q    <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lim_r_q <= lim_r_d;
      lim_c_q <= lim_c_d;
      wr_q    <= wr_d;
      wc_q    <= wc_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = state_q == DONE || err_q;
  assign bus.cfg_err   = err_q;
  assign bus.stack_en  = state_q == SETUP || state_q == RUN || state_q == TURN;
  assign bus.shift_dir = dir_q;
  assign bus.turn      = state_q == TURN;
  assign bus.win_valid = state_q == RUN;
  assign bus.win_row   = wr_q;
  assign bus.win_col   = wc_q;
`ifdef SNAKE_CTRL_STATS_EN
  logic [19:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = (state_q == IDLE && state_d == SETUP) ? '0 :
            (state_q != IDLE && cnt_q != '1) ? cnt_q + 20'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign bus.cycle_cnt = cnt_q;
`else
  assign bus.cycle_cnt = '0;
`endif
endmodule

// File: tb/tb_snake_scan_ctrl.sv
// tb_snake_scan_ctrl: directed plus randomized passes compared cycle by cycle against a scan-order model
module tb_snake_scan_ctrl;
  localparam int DW = 9;
  typedef logic [31:0] vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   last_cnt = 0;
  vec_t flg;
  vec_t ex[$];
  vec_t mk[$];
  snake_scan_ctrl_if #(.DIM_W(DW)) u ();
  snake_scan_ctrl #(.DIM_W(DW), .K(3)) dut (.clk(clk), .rst_n(rst_n), .bus(u.slave));
  always #5 clk = ~clk;
  function automatic vec_t pk(input logic b, d, e, s, sd, t, v, input int r, c);
    return {7'd0, b, d, e, s, sd, t, v, DW'(r), DW'(c)};
  endfunction
  function automatic vec_t obs();
    return {7'd0, u.busy, u.done, u.cfg_err, u.stack_en, u.shift_dir, u.turn, u.win_valid, u.win_row, u.win_col};
  endfunction
  task automatic check(input string tag, input vec_t got, input vec_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic build(input int r, input int c);
    int w, h, cc;
    ex.delete();
    mk.delete();
    if (r < 3 || c < 3) begin
      ex.push_back(pk(0, 1, 1, 0, 0, 0, 0, 0, 0));
      mk.push_back(flg);
      return;
    end
    w = c - 2;
    h = r - 2;
    ex.push_back(pk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    mk.push_back('1);
    for (int rr = 0; rr < h; rr++) begin
      for (int i = 0; i < w; i++) begin
        cc = (rr % 2 == 1) ? w - 1 - i : i;
        ex.push_back(pk(1, 0, 0, 1, rr % 2, 0, 1, rr, cc));
        mk.push_back('1);
      end
      if (rr < h - 1) begin
        ex.push_back(pk(1, 0, 0, 1, rr % 2, 1, 0, rr, (rr % 2 == 1) ? 0 : w - 1));
        mk.push_back('1);
      end
    end
    ex.push_back(pk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    mk.push_back(flg);
  endtask
  task automatic run_pass(input int r, input int c, input int ign, input int abort_at, input string nm);
    int n;
    vec_t exp_cnt;
    build(r, c);
    n = ex.size();
    u.row = DW'(r);
    u.col = DW'(c);
    u.start = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      u.start = (k == ign);
      check($sformatf("%s r%0d c%0d cyc%0d", nm, r, c, k), obs() & mk[k-1], ex[k-1]);
      if (k == abort_at) begin
        #1 rst_n = 1'b0;
        #1 check($sformatf("%s async reset outputs", nm), obs(), 0);
        check($sformatf("%s async reset cnt", nm), {12'd0, u.cycle_cnt}, 0);
        last_cnt = 0;
        return;
      end
    end
    @(negedge clk);
    u.start = 1'b0;
    check($sformatf("%s r%0d c%0d idle", nm, r, c), obs() & flg, 0);
    if (r >= 3 && c >= 3) last_cnt = n;
`ifdef SNAKE_CTRL_STATS_EN
    exp_cnt = vec_t'(last_cnt);
`else
    exp_cnt = 0;
`endif
    check($sformatf("%s cycle_cnt", nm), {12'd0, u.cycle_cnt}, exp_cnt);
  endtask
  initial begin
    int r, c;
    u.start = 1'b0;
    u.row = '0;
    u.col = '0;
    flg = pk(1, 1, 1, 1, 0, 1, 1, 0, 0);
    #2 check("reset outputs", obs(), 0);
    check("reset cnt", {12'd0, u.cycle_cnt}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_pass(5, 6, 5, 0, "5x6 ignored start");
    run_pass(5, 6, 0, 0, "5x6 back to back");
    run_pass(3, 3, 0, 0, "3x3");
    run_pass(2, 8, 0, 0, "reject 2x8");
    run_pass(8, 2, 0, 0, "reject 8x2");
    run_pass(5, 6, 0, 8, "5x6 reset");
    @(negedge clk);
    check("held in reset", obs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_pass(5, 6, 0, 0, "5x6 after reset");
    for (int i = 0; i < 25; i++) begin
      r = $urandom_range(0, 10);
      c = $urandom_range(0, 12);
      run_pass(r, c, $urandom_range(2, 12), 0, $sformatf("rand%0d", i));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
